// File: rtl/tls_pkg.sv
// Shared types and constants for the traffic-light command generator.
package tls_pkg;

    localparam int unsigned DUR_W       = 4;
    localparam int unsigned DEB_LEN_DEF = 4;
    localparam int unsigned DEB_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        JUMPED = 2'd3
    } state_e;

    // A zero-length phase would stall the downstream controller, so it becomes one second.
    function automatic logic [DUR_W-1:0] dur_clamp(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

endpackage

// File: rtl/tls_debounce.sv
// Pedestrian-button debouncer: one press per hold after DEB_LEN consecutive high samples.
module tls_debounce
    import tls_pkg::*;
#(
    parameter int unsigned DEB_LEN = DEB_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_c
);

    logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
    logic                 fired_q, fired_d;

    // The press fires on the same edge that samples the final high; fired_q blocks repeats until release.
    always_comb begin
        cnt_d   = cnt_q;
        fired_d = fired_q;
        press_c = 1'b0;
        if (!btn_i) begin
            cnt_d   = '0;
            fired_d = 1'b0;
        end else if (!fired_q) begin
            if (cnt_q == DEB_CNT_W'(DEB_LEN - 1)) begin
                press_c = 1'b1;
                fired_d = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + DEB_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            fired_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fired_q <= fired_d;
        end
    end

endmodule

// File: rtl/tls_cmd_gen.sv
// Command generator: loads phase durations, turns debounced pedestrian presses into
// one force-to-red jump per light cycle, and forwards emergency holds.
module tls_cmd_gen
    import tls_pkg::*;
#(
    parameter int unsigned DEB_LEN = DEB_LEN_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [DUR_W-1:0] cfg_g,
    input  logic [DUR_W-1:0] cfg_y,
    input  logic [DUR_W-1:0] cfg_r,
    output logic             cfg_ready,
    input  logic             ped_btn,
    input  logic             emg,
    input  logic             g_lamp,
    input  logic             y_lamp,
    input  logic             r_lamp,
    output logic             set,
    output logic             stop,
    output logic             jump,
    output logic [DUR_W-1:0] G_in,
    output logic [DUR_W-1:0] Y_in,
    output logic [DUR_W-1:0] R_in
);

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic             seen_red_q, seen_red_d;
    logic             set_q, set_d;
    logic             stop_q, stop_d;
    logic             jump_q, jump_d;
    logic             ready_q, ready_d;
    logic [DUR_W-1:0] g_q, g_d, y_q, y_d, r_q, r_d;
    logic             press_c;
    logic             accept_c;
    logic             lamp_ok_c;

    tls_debounce #(.DEB_LEN(DEB_LEN)) u_deb (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (ped_btn),
        .press_c (press_c)
    );

    assign accept_c  = cfg_valid & ready_q;
    assign lamp_ok_c = (g_lamp | y_lamp) & ~r_lamp;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        seen_red_d = seen_red_q;
        g_d        = g_q;
        y_d        = y_q;
        r_d        = r_q;
        set_d      = 1'b0;
        jump_d     = 1'b0;
        stop_d     = emg;

        case (state_q)
            IDLE: ;
            LOAD: begin
                set_d   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (press_c && lamp_ok_c) pending_d = 1'b1;
                if (pending_q && !stop_q) begin
                    jump_d     = 1'b1;
                    pending_d  = 1'b0;
                    seen_red_d = 1'b0;
                    state_d    = JUMPED;
                end
            end
            JUMPED: begin
                // Red must be seen before green so only a fresh light cycle re-arms the jump.
                if (!seen_red_q) begin
                    seen_red_d = r_lamp;
                end else if (g_lamp) begin
                    seen_red_d = 1'b0;
                    state_d    = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new configuration overrides any jump decided on the same edge.
        if (accept_c) begin
            g_d        = dur_clamp(cfg_g);
            y_d        = dur_clamp(cfg_y);
            r_d        = dur_clamp(cfg_r);
            pending_d  = 1'b0;
            seen_red_d = 1'b0;
            jump_d     = 1'b0;
            state_d    = LOAD;
        end

        ready_d = (state_d != LOAD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            seen_red_q <= 1'b0;
            set_q      <= 1'b0;
            stop_q     <= 1'b0;
            jump_q     <= 1'b0;
            ready_q    <= 1'b1;
            g_q        <= '0;
            y_q        <= '0;
            r_q        <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            seen_red_q <= seen_red_d;
            set_q      <= set_d;
            stop_q     <= stop_d;
            jump_q     <= jump_d;
            ready_q    <= ready_d;
            g_q        <= g_d;
            y_q        <= y_d;
            r_q        <= r_d;
        end
    end

    assign cfg_ready = ready_q;
    assign set       = set_q;
    assign stop      = stop_q;
    assign jump      = jump_q;
    assign G_in      = g_q;
    assign Y_in      = y_q;
    assign R_in      = r_q;

endmodule

// File: tb/tb_tls_cmd_gen.sv
// Scenario bench for tls_cmd_gen; expected behaviour is derived from the block's timing rules.
module tb_tls_cmd_gen;

    localparam int unsigned DEB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic [3:0] cfg_g, cfg_y, cfg_r;
    logic       cfg_ready;
    logic       ped_btn, emg, g_lamp, y_lamp, r_lamp;
    logic       set, stop, jump;
    logic [3:0] G_in, Y_in, R_in;

    int checks = 0;
    int errors = 0;

    tls_cmd_gen #(.DEB_LEN(DEB)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_g     (cfg_g),
        .cfg_y     (cfg_y),
        .cfg_r     (cfg_r),
        .cfg_ready (cfg_ready),
        .ped_btn   (ped_btn),
        .emg       (emg),
        .g_lamp    (g_lamp),
        .y_lamp    (y_lamp),
        .r_lamp    (r_lamp),
        .set       (set),
        .stop      (stop),
        .jump      (jump),
        .G_in      (G_in),
        .Y_in      (Y_in),
        .R_in      (R_in)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lamps(input int which);
        g_lamp = (which == 0);
        y_lamp = (which == 1);
        r_lamp = (which == 2);
    endtask

    // Drives one red then one green sample so a JUMPED controller re-arms.
    task automatic return_to_run();
        ped_btn = 1'b0;
        set_lamps(2);
        tick();
        set_lamps(0);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_valid = 1'b0; cfg_g = '0; cfg_y = '0; cfg_r = '0;
        ped_btn = 1'b0; emg = 1'b0; set_lamps(3);
        tick(); tick();
        checks++; if (set !== 1'b0) begin errors++; $display("FAIL reset_set: got %b expected 0", set); end
        checks++; if (stop !== 1'b0) begin errors++; $display("FAIL reset_stop: got %b expected 0", stop); end
        checks++; if (jump !== 1'b0) begin errors++; $display("FAIL reset_jump: got %b expected 0", jump); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
        checks++; if ({G_in, Y_in, R_in} !== 12'h000) begin errors++; $display("FAIL reset_dur: got %h expected 000", {G_in, Y_in, R_in}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cfg(input logic [3:0] g, input logic [3:0] y, input logic [3:0] r);
        logic [3:0] eg, ey, er;
        eg = (g == 4'd0) ? 4'd1 : g;
        ey = (y == 4'd0) ? 4'd1 : y;
        er = (r == 4'd0) ? 4'd1 : r;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_pre: got %b expected 1", cfg_ready); end
        cfg_valid = 1'b1; cfg_g = g; cfg_y = y; cfg_r = r;
        tick();
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_load: got %b expected 0", cfg_ready); end
        checks++; if (set !== 1'b0) begin errors++; $display("FAIL cfg_set_early: got %b expected 0", set); end
        checks++; if ({G_in, Y_in, R_in} !== {eg, ey, er}) begin errors++; $display("FAIL cfg_dur: got %h expected %h", {G_in, Y_in, R_in}, {eg, ey, er}); end
        tick();
        checks++; if (set !== 1'b1) begin errors++; $display("FAIL cfg_set: got %b expected 1", set); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_run: got %b expected 1", cfg_ready); end
        checks++; if ({G_in, Y_in, R_in} !== {eg, ey, er}) begin errors++; $display("FAIL cfg_dur_hold: got %h expected %h", {G_in, Y_in, R_in}, {eg, ey, er}); end
        tick();
        checks++; if (set !== 1'b0) begin errors++; $display("FAIL cfg_set_once: got %b expected 0", set); end
    endtask

    task automatic test_cfg_random();
        for (int i = 0; i < 6; i++)
            test_cfg(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    endtask

    task automatic test_press_jump();
        int extra;
        set_lamps(0);
        ped_btn = 1'b1;
        for (int e = 1; e <= DEB; e++) begin
            tick();
            checks++; if (jump !== 1'b0) begin errors++; $display("FAIL press_early_jump edge %0d: got %b expected 0", e, jump); end
        end
        tick();
        checks++; if (jump !== 1'b1) begin errors++; $display("FAIL press_jump: got %b expected 1", jump); end
        checks++; if (set !== 1'b0) begin errors++; $display("FAIL press_jump_set: got %b expected 0", set); end
        tick();
        checks++; if (jump !== 1'b0) begin errors++; $display("FAIL press_jump_width: got %b expected 0", jump); end
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (jump === 1'b1) extra++;
        end
        // A fresh press before the red phase must also be ignored.
        ped_btn = 1'b0; tick(); ped_btn = 1'b1;
        for (int c = 0; c < DEB + 3; c++) begin
            tick();
            if (jump === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL press_second_jump: got %0d jumps expected 0", extra); end
        return_to_run();
    endtask

    task automatic test_press_random();
        int n, lamp, njump, first, exp_n;
        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(1, 7);
            lamp = $urandom_range(0, 2);
            set_lamps(lamp);
            exp_n = (n >= DEB && lamp != 2) ? 1 : 0;
            njump = 0; first = -1;
            for (int e = 1; e <= 10; e++) begin
                ped_btn = (e <= n);
                tick();
                if (jump === 1'b1) begin
                    njump++;
                    if (first < 0) first = e;
                end
            end
            checks++; if (njump !== exp_n) begin errors++; $display("FAIL rand_press n=%0d lamp=%0d: got %0d jumps expected %0d", n, lamp, njump, exp_n); end
            if (exp_n == 1) begin
                checks++; if (first !== DEB + 1) begin errors++; $display("FAIL rand_press_edge: got %0d expected %0d", first, DEB + 1); end
            end
            if (njump != 0) return_to_run();
            set_lamps(0);
            ped_btn = 1'b0;
            tick();
        end
    endtask

    task automatic test_emg();
        int bad;
        set_lamps(0);
        ped_btn = 1'b1;
        tick();
        emg = 1'b1;
        tick();
        checks++; if (stop !== 1'b1) begin errors++; $display("FAIL emg_stop: got %b expected 1", stop); end
        bad = 0;
        for (int e = 0; e < 6; e++) begin
            tick();
            if (jump !== 1'b0 || stop !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL emg_hold: got %0d bad cycles expected 0", bad); end
        emg = 1'b0;
        tick();
        checks++; if (stop !== 1'b0) begin errors++; $display("FAIL emg_stop_fall: got %b expected 0", stop); end
        checks++; if (jump !== 1'b0) begin errors++; $display("FAIL emg_jump_early: got %b expected 0", jump); end
        tick();
        checks++; if (jump !== 1'b1) begin errors++; $display("FAIL emg_jump_after: got %b expected 1", jump); end
        return_to_run();
    endtask

    task automatic test_collision();
        int extra;
        set_lamps(0);
        ped_btn = 1'b1;
        repeat (DEB) tick();
        cfg_valid = 1'b1; cfg_g = 4'd9; cfg_y = 4'd8; cfg_r = 4'd0;
        tick();
        cfg_valid = 1'b0;
        checks++; if (jump !== 1'b0) begin errors++; $display("FAIL coll_jump: got %b expected 0", jump); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL coll_ready: got %b expected 0", cfg_ready); end
        tick();
        checks++; if (set !== 1'b1 || jump !== 1'b0) begin errors++; $display("FAIL coll_set: got set=%b jump=%b expected set=1 jump=0", set, jump); end
        checks++; if ({G_in, Y_in, R_in} !== 12'h981) begin errors++; $display("FAIL coll_dur: got %h expected 981", {G_in, Y_in, R_in}); end
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (jump === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL coll_late_jump: got %0d expected 0", extra); end
        ped_btn = 1'b0;
        tick();
    endtask

    task automatic test_cfg_in_jumped();
        set_lamps(0);
        ped_btn = 1'b1;
        repeat (DEB + 1) tick();
        checks++; if (jump !== 1'b1) begin errors++; $display("FAIL jmpcfg_jump: got %b expected 1", jump); end
        ped_btn = 1'b0;
        cfg_valid = 1'b1; cfg_g = 4'd3; cfg_y = 4'd4; cfg_r = 4'd5;
        tick();
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL jmpcfg_ready: got %b expected 0", cfg_ready); end
        tick();
        checks++; if (set !== 1'b1 || {G_in, Y_in, R_in} !== 12'h345) begin errors++; $display("FAIL jmpcfg_set: got set=%b dur=%h expected set=1 dur=345", set, {G_in, Y_in, R_in}); end
        tick();
    endtask

    task automatic test_reset_jumped();
        int extra;
        set_lamps(0);
        ped_btn = 1'b1;
        repeat (DEB + 1) tick();
        checks++; if (jump !== 1'b1) begin errors++; $display("FAIL rstj_jump: got %b expected 1", jump); end
        emg = 1'b1; reset = 1'b1;
        tick();
        checks++; if ({set, stop, jump, cfg_ready} !== 4'b0001) begin errors++; $display("FAIL rstj_ctrl: got %b expected 0001", {set, stop, jump, cfg_ready}); end
        checks++; if ({G_in, Y_in, R_in} !== 12'h000) begin errors++; $display("FAIL rstj_dur: got %h expected 000", {G_in, Y_in, R_in}); end
        reset = 1'b0; emg = 1'b0; ped_btn = 1'b0;
        tick();
        // IDLE ignores presses, so no jump may appear before a new configuration.
        ped_btn = 1'b1;
        extra = 0;
        for (int c = 0; c < DEB + 4; c++) begin
            tick();
            if (jump === 1'b1 || set === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL idle_press: got %0d strobes expected 0", extra); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", cfg_ready); end
        ped_btn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cfg(4'd5, 4'd2, 4'd7);
        test_cfg(4'd0, 4'd3, 4'd0);
        test_cfg_random();
        test_press_jump();
        test_press_random();
        test_emg();
        test_collision();
        test_cfg_in_jumped();
        test_reset_jumped();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tls_cmd_gen.md
TLS_CMD_GEN -- requirements
Module: tls_cmd_gen

Interface
REQ-001 Parameter DEB_LEN, default 4: consecutive high samples of ped_btn that make one press (range 2..15).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 cfg_valid  input  1  a new phase-duration set is offered.
REQ-005 cfg_g, cfg_y, cfg_r  input  4 each  offered green, yellow and red durations in seconds.
REQ-006 cfg_ready  output  1  the block accepts a configuration this cycle.
REQ-007 ped_btn  input  1  raw pedestrian button, level, already synchronous to clk.
REQ-008 emg  input  1  emergency hold request, level.
REQ-009 g_lamp, y_lamp, r_lamp  input  1 each  lamp state fed back from the downstream light controller.
REQ-010 set  output  1  one-cycle load strobe to the downstream controller.
REQ-011 stop  output  1  hold strobe to the downstream controller.
REQ-012 jump  output  1  one-cycle strobe that forces the downstream controller to red.
REQ-013 G_in, Y_in, R_in  output  4 each  registered durations, valid whenever set=1 and held afterwards.

Function
REQ-014 The state machine SHALL have the states IDLE, LOAD, RUN and JUMPED, and every output SHALL be registered.
REQ-015 A configuration SHALL be accepted on an edge where cfg_valid=1 and cfg_ready=1; cfg_ready SHALL be 1 in IDLE, RUN and JUMPED, and 0 in LOAD.
REQ-016 On acceptance, G_in, Y_in and R_in SHALL load the offered values, with any value of 0 replaced by 1, and the state SHALL go to LOAD.
REQ-017 In LOAD, set SHALL be 1 for exactly one cycle, after which the state SHALL go to RUN; set SHALL be 0 in every other state.
REQ-018 A press SHALL be detected on the edge that sees the DEB_LEN-th consecutive high sample of ped_btn.
REQ-019 Only one press SHALL be detected per hold; ped_btn must be sampled low before another press can be detected.
REQ-020 A detected press SHALL set a pending flag only in RUN with g_lamp=1 or y_lamp=1; otherwise (IDLE, LOAD, JUMPED, or r_lamp=1) the press SHALL be discarded.
REQ-021 jump SHALL be 1 for the one cycle after the edge where pending=1, stop=0 and the state is RUN; on that edge pending SHALL clear and the state SHALL go to JUMPED.
REQ-022 JUMPED SHALL wait for r_lamp=1, then for g_lamp=1, and SHALL then return to RUN, so at most one jump is issued per light cycle.
REQ-023 stop SHALL equal emg delayed by one edge, in every state.
REQ-024 While stop=1, no jump SHALL be issued and pending SHALL be held.
REQ-025 When a configuration is accepted on the same edge as a jump would be issued, the configuration SHALL win: pending clears, no jump is issued, and the state goes to LOAD.
REQ-026 A configuration accepted in JUMPED SHALL abandon the wait and go to LOAD.
REQ-027 set and stop MAY both be 1 in the same cycle; jump and set SHALL never both be 1.

Reset
REQ-028 On an edge with reset=1: state IDLE, set=0, stop=0, jump=0, G_in=Y_in=R_in=0, cfg_ready=1, pending cleared, debounce counter and release flag cleared.
REQ-029 Reset SHALL take priority over every other input, including a reset that arrives mid-debounce, in LOAD, or in JUMPED.

Structure
REQ-030 A shared package tls_pkg SHALL hold the state enumeration, the duration width (4) and the DEB_LEN default.
REQ-031 The debounce logic (counter, release flag, one-cycle press output) SHALL be the sub-module tls_debounce.

Verification
REQ-032 Reset, then cfg 5/2/7 with cfg_valid held -> accepted on edge 1, set=1 for one cycle after edge 2, G_in/Y_in/R_in=5/2/7, cfg_ready=0 only during LOAD.
REQ-033 cfg 0/3/0 -> G_in/Y_in/R_in=1/3/1.
REQ-034 RUN with g_lamp=1, ped_btn high for 4 edges -> pending at edge 4, jump=1 for one cycle after edge 5; holding the button 20 more cycles -> no second jump.
REQ-035 Press with r_lamp=1 -> no jump; ped_btn high only 3 edges -> no jump.
REQ-036 emg=1 before the press completes -> stop=1 one edge later and no jump; emg=0 -> jump issued one edge after stop falls.
REQ-037 cfg_valid on the same edge as a pending jump -> set pulse, no jump; reset asserted in JUMPED -> IDLE with all outputs at reset values.
